// File: rtl/dm_pkg.sv
// Debug-module shared types for the TCK-side DMI path.
// Holds the DMI request/response payloads, the DTM op and response codes,
// and the state encoding of the DMI request arbiter.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // Response codes carried in dmi_resp_t.resp
    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        Fwd      = 2'd1,
        WaitResp = 2'd2,
        Respond  = 2'd3
    } dmi_arb_state_e;

endpackage

// File: rtl/dmi_rr_picker.sv
// Combinational round-robin picker.
// Searches req_i starting at index ptr_i (wrapping) and returns the first
// set bit as a one-hot grant plus its index.
// Ports:
//   req_i    requests, one bit per requester
//   ptr_i    index with highest priority this cycle (must be < NumReq)
//   gnt_o    one-hot grant (zero when no request)
//   idx_o    index of the granted requester
//   valid_o  at least one request present
module dmi_rr_picker #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int unsigned       cand_int;
    logic [IdxW-1:0]   cand;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand_int = (32'(ptr_i) + k) % NumReq;
            cand     = IdxW'(cand_int);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmi_req_arbiter.sv
// DMI request arbiter (TCK domain).
// Shares the single DMI request/response channel into the DMI CDC between
// NumReq requesters (0 = JTAG DTM, 1+ = auxiliary TCK-side masters).
// Round-robin grant, one transaction outstanding at a time, response routed
// back to its owner. A response-wait timeout synthesizes a DTM_ERR response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// Idle     | choose next owner round-robin from req_valid_i
// Fwd      | owner's request presented to the CDC until accepted
// WaitResp | waiting for CDC response, timeout counter running
// Respond  | registered response held to owner until resp_ready_i
//
// Ports:
//   tck_i, trst_ni        clock, async active-low reset
//   dmi_clear_i           synchronous abort back to Idle
//   req_valid_i/ready_o   per-requester request handshake
//   req_i                 per-requester request payload
//   resp_valid_o/ready_i  per-requester response handshake
//   resp_o                shared response payload
//   dmi_req_*             request channel to the CDC
//   dmi_resp_*            response channel from the CDC
//   stale_resp_o          pulse when a CDC response is discarded
module dmi_req_arbiter
    import dm::*;
#(
    parameter  int unsigned NumReq        = 2,
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned TimeoutW      = $clog2(TimeoutCycles + 1),
    localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              tck_i,
    input  logic              trst_ni,
    input  logic              dmi_clear_i,
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    input  dmi_req_t          req_i [NumReq],
    output logic [NumReq-1:0] resp_valid_o,
    input  logic [NumReq-1:0] resp_ready_i,
    output dmi_resp_t         resp_o,
    output dmi_req_t          dmi_req_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    input  dmi_resp_t         dmi_resp_i,
    input  logic              dmi_resp_valid_i,
    output logic              dmi_resp_ready_o,
    output logic              stale_resp_o
);

    dmi_arb_state_e    state_q;
    logic [IdxW-1:0]   owner_q;
    logic [NumReq-1:0] owner_oh_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [IdxW-1:0]   rr_ptr_d;
    logic [TimeoutW-1:0] cnt_q;
    dmi_resp_t         resp_q;

    logic [NumReq-1:0] pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;

    dmi_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign rr_ptr_d = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q    <= Idle;
            owner_q    <= '0;
            owner_oh_q <= NumReq'(1);
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
        end else if (dmi_clear_i) begin
            state_q    <= Idle;
            owner_q    <= '0;
            owner_oh_q <= NumReq'(1);
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (pick_valid) begin
                        owner_q    <= pick_idx;
                        owner_oh_q <= pick_gnt;
                        rr_ptr_q   <= rr_ptr_d;
                        state_q    <= Fwd;
                    end
                end
                Fwd: begin
                    if (dmi_req_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= WaitResp;
                    end
                end
                WaitResp: begin
                    // A real response beats a timeout expiring in the same cycle.
                    if (dmi_resp_valid_i) begin
                        resp_q  <= dmi_resp_i;
                        state_q <= Respond;
                    end else if (cnt_q == TimeoutW'(TimeoutCycles - 1)) begin
                        resp_q  <= '{data: '0, resp: DTM_ERR};
                        state_q <= Respond;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                Respond: begin
                    if (resp_ready_i[owner_q]) begin
                        state_q <= Idle;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    // Request handshake passes straight through so the owner sees ready in
    // the same cycle the CDC accepts; clear suppresses both directions.
    assign dmi_req_o        = req_i[owner_q];
    assign dmi_req_valid_o  = (state_q == Fwd) && !dmi_clear_i;
    assign req_ready_o      = (dmi_req_valid_o && dmi_req_ready_i) ? owner_oh_q : '0;
    assign resp_valid_o     = ((state_q == Respond) && !dmi_clear_i) ? owner_oh_q : '0;
    assign resp_o           = resp_q;
    assign dmi_resp_ready_o = 1'b1;
    // Any response not captured in WaitResp is consumed and flagged.
    assign stale_resp_o     = dmi_resp_valid_i && (dmi_clear_i || (state_q != WaitResp));

    a_req_ready_onehot: assert property (@(posedge tck_i) disable iff (!trst_ni)
        $onehot0(req_ready_o));

    a_resp_valid_onehot: assert property (@(posedge tck_i) disable iff (!trst_ni)
        $onehot0(resp_valid_o));

    a_req_stable: assert property (@(posedge tck_i) disable iff (!trst_ni)
        (dmi_req_valid_o && !dmi_req_ready_i) |=> (!dmi_req_valid_o || $stable(dmi_req_o)));

    a_owner_holds_valid: assert property (@(posedge tck_i) disable iff (!trst_ni || dmi_clear_i)
        (state_q == Fwd) |-> req_valid_i[owner_q]);

endmodule

// File: tb/tb_dmi_req_arbiter.sv
module tb_dmi_req_arbiter;
    import dm::*;

    localparam int NUM = 2;
    localparam int TO  = 8;

    logic            tck = 1'b0;
    logic            trst_n;
    logic            dmi_clear;
    logic [NUM-1:0]  req_valid;
    logic [NUM-1:0]  req_ready;
    dmi_req_t        req [NUM];
    logic [NUM-1:0]  resp_valid;
    logic [NUM-1:0]  resp_ready;
    dmi_resp_t       resp_o;
    dmi_req_t        dmi_req;
    logic            dmi_req_valid;
    logic            dmi_req_ready;
    dmi_resp_t       dmi_resp;
    logic            dmi_resp_valid;
    logic            dmi_resp_ready;
    logic            stale;

    int total = 0;
    int bad   = 0;
    int exp_ptr = 0;

    typedef struct {
        int          own;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;
    exp_t sb [$];

    always #5 tck = ~tck;

    dmi_req_arbiter #(
        .NumReq        (NUM),
        .TimeoutCycles (TO)
    ) dut (
        .tck_i            (tck),
        .trst_ni          (trst_n),
        .dmi_clear_i      (dmi_clear),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_i            (req),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_o           (resp_o),
        .dmi_req_o        (dmi_req),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_resp_i       (dmi_resp),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .stale_resp_o     (stale)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM-1:0] oh(input int i);
        oh = NUM'(1) << i;
    endfunction

    // Reference round-robin: first valid index at or after ptr, wrapping.
    function automatic int pick(input logic [NUM-1:0] v, input int p);
        for (int k = 0; k < NUM; k++) begin
            if (v[(p + k) % NUM]) return (p + k) % NUM;
        end
        return 0;
    endfunction

    task automatic check_resp();
        exp_t e;
        chk("sb_pending", (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("resp_valid", resp_valid, oh(e.own));
        chk("resp_payload", resp_o, {e.data, e.code});
        chk("no_stale", stale, 0);
    endtask

    // Waits for the CDC request, checks it belongs to the model's owner,
    // lets the handshake complete, then drops or renews the request.
    task automatic grant_only(input logic hold, output int own);
        int n = 0;
        #1;
        while (dmi_req_valid !== 1'b1 && n < 30) begin
            @(negedge tck); #1;
            n++;
        end
        chk("fwd_seen", dmi_req_valid, 1);
        own     = pick(req_valid, exp_ptr);
        exp_ptr = (own + 1) % NUM;
        chk("fwd_payload", dmi_req, req[own]);
        chk("req_ready_grant", req_ready, oh(own));
        @(negedge tck);
        if (hold) req[own].data = req[own].data + 32'h1;
        else      req_valid[own] = 1'b0;
        #1;
        chk("req_ready_after", req_ready, 0);
        chk("req_valid_after", dmi_req_valid, 0);
    endtask

    task automatic serve(input logic hold, input int lat, input logic [31:0] d,
                         input logic [1:0] code, output int own);
        grant_only(hold, own);
        repeat (lat - 1) @(negedge tck);
        dmi_resp_valid = 1'b1;
        dmi_resp       = '{data: d, resp: code};
        sb.push_back('{own, d, code});
        #1;
        chk("resp_not_early", resp_valid, 0);
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        #1;
        check_resp();
    endtask

    initial begin
        int own;
        int n;
        trst_n         = 1'b0;
        dmi_clear      = 1'b0;
        req_valid      = '0;
        req[0]         = '0;
        req[1]         = '0;
        resp_ready     = 2'b11;
        dmi_req_ready  = 1'b1;
        dmi_resp       = '0;
        dmi_resp_valid = 1'b0;

        // reset values
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_dmi_req_valid", dmi_req_valid, 0);
        chk("rst_dmi_resp_ready", dmi_resp_ready, 1);
        chk("rst_stale", stale, 0);
        chk("rst_resp_o", resp_o, 0);
        @(negedge tck);
        @(negedge tck);
        trst_n = 1'b1;

        // single read from requester 0, response 3 cycles after acceptance
        @(negedge tck);
        req[0]    = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
        req_valid = 2'b01;
        #1;
        chk("idle_no_ready", req_ready, 0);
        chk("idle_no_valid", dmi_req_valid, 0);
        @(negedge tck); #1;
        chk("grant_latency", dmi_req_valid, 1);
        serve(1'b0, 3, 32'hCAFE0001, DTM_SUCCESS, own);

        // timeout on a write from requester 1, then a late response
        @(negedge tck);
        req[1]    = '{addr: 7'h05, op: DTM_WRITE, data: 32'hDEAD0000};
        req_valid = 2'b10;
        grant_only(1'b0, own);
        sb.push_back('{own, 32'h0, DTM_ERR});
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge tck); #1;
            chk("timeout_wait", resp_valid, 0);
        end
        @(negedge tck); #1;
        chk("timeout_owner", own, 1);
        check_resp();
        @(negedge tck);
        dmi_resp_valid = 1'b1;
        dmi_resp       = '{data: 32'h12345678, resp: DTM_SUCCESS};
        #1;
        chk("late_stale", stale, 1);
        chk("late_no_resp", resp_valid, 0);
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        #1;
        chk("late_stale_pulse", stale, 0);
        chk("late_no_resp2", resp_valid, 0);
        chk("late_no_req", dmi_req_valid, 0);

        // both requesters held valid: alternating grants
        req[0]    = '{addr: 7'h20, op: DTM_READ, data: 32'h0};
        req[1]    = '{addr: 7'h30, op: DTM_WRITE, data: 32'h1000};
        req_valid = 2'b11;
        serve(1'b1, 1, 32'hA0000000, DTM_SUCCESS, own);
        chk("rr_grant0", own, 0);
        serve(1'b1, 2, 32'hA0000001, DTM_SUCCESS, own);
        chk("rr_grant1", own, 1);
        serve(1'b1, 1, 32'hA0000002, DTM_SUCCESS, own);
        chk("rr_grant2", own, 0);
        req_valid[0] = 1'b0;
        serve(1'b0, 3, 32'hA0000003, DTM_BUSY, own);
        chk("rr_grant3", own, 1);

        // clear during WaitResp with a response arriving in the same cycle
        @(negedge tck);
        req[0]    = '{addr: 7'h12, op: DTM_READ, data: 32'h0};
        req_valid = 2'b01;
        grant_only(1'b0, own);
        @(negedge tck);
        dmi_clear      = 1'b1;
        dmi_resp_valid = 1'b1;
        dmi_resp       = '{data: 32'hBAD0BAD0, resp: DTM_SUCCESS};
        #1;
        chk("clear_stale", stale, 1);
        chk("clear_no_resp", resp_valid, 0);
        chk("clear_no_ready", req_ready, 0);
        @(negedge tck);
        dmi_clear      = 1'b0;
        dmi_resp_valid = 1'b0;
        exp_ptr        = 0;
        #1;
        chk("after_clear_no_resp", resp_valid, 0);
        chk("after_clear_idle", dmi_req_valid, 0);
        req[0]    = '{addr: 7'h13, op: DTM_READ, data: 32'h0};
        req[1]    = '{addr: 7'h14, op: DTM_WRITE, data: 32'h77};
        req_valid = 2'b11;
        serve(1'b0, 2, 32'hC1EA0000, DTM_SUCCESS, own);
        chk("post_clear_grant", own, 0);
        serve(1'b0, 1, 32'hC1EA0001, DTM_SUCCESS, own);

        // owner 0 stalls the response; pending requester 1 must wait
        @(negedge tck);
        resp_ready = 2'b10;
        req[0]     = '{addr: 7'h40, op: DTM_READ, data: 32'h0};
        req[1]     = '{addr: 7'h41, op: DTM_WRITE, data: 32'h99};
        req_valid  = 2'b11;
        serve(1'b0, 2, 32'h5555AAAA, DTM_SUCCESS, own);
        for (int i = 0; i < 5; i++) begin
            @(negedge tck); #1;
            chk("stall_resp_valid", resp_valid, 2'b01);
            chk("stall_resp_o", resp_o, {32'h5555AAAA, DTM_SUCCESS});
            chk("stall_no_grant", dmi_req_valid, 0);
        end
        resp_ready = 2'b11;
        serve(1'b0, 1, 32'h5555BBBB, DTM_ERR, own);
        chk("stall_then_req1", own, 1);

        // asynchronous reset while a request sits in Fwd
        @(negedge tck);
        dmi_req_ready = 1'b0;
        req[0]        = '{addr: 7'h50, op: DTM_READ, data: 32'h0};
        req_valid     = 2'b01;
        n = 0;
        #1;
        while (dmi_req_valid !== 1'b1 && n < 30) begin
            @(negedge tck); #1;
            n++;
        end
        chk("fwd_before_reset", dmi_req_valid, 1);
        #2;
        trst_n = 1'b0;
        #1;
        chk("arst_dmi_req_valid", dmi_req_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_stale", stale, 0);
        chk("arst_resp_o", resp_o, 0);
        chk("arst_dmi_resp_ready", dmi_resp_ready, 1);
        @(negedge tck);
        trst_n        = 1'b1;
        exp_ptr       = 0;
        dmi_req_ready = 1'b1;
        serve(1'b0, 2, 32'h0BADF00D, DTM_SUCCESS, own);
        chk("resume_owner", own, 0);

        @(negedge tck);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
